// File: rtl/pair_match_engine.sv
// pair_match_engine: reveal/compare/hide rules for the 8-square colour-matching game.
// Holds the hidden colour of every square, tracks which squares are hidden, revealed
// or matched, counts matched pairs and missed attempts, and flags the end of a game.
module pair_match_engine #(
    parameter int COLOR_W     = 3,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic                 clk25MHz,
    input  logic                 rst,
    input  logic                 new_game,
    input  logic [8*COLOR_W-1:0] colors,
    input  logic                 sel_valid,
    input  logic [2:0]           sel_index,
    output logic [15:0]          square_state,
    output logic [2:0]           match_count,
    output logic [7:0]           miss_count,
    output logic                 match_pulse,
    output logic                 miss_pulse,
    output logic                 busy,
    output logic                 game_over
);

    // Hold counter only has to reach HOLD_CYCLES-1; keep at least one bit for HOLD_CYCLES=1.
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] SQ_HIDDEN   = 2'b00;
    localparam logic [1:0] SQ_REVEALED = 2'b10;
    localparam logic [1:0] SQ_MATCHED  = 2'b11;

    typedef enum logic [2:0] {
        WAIT_NEW,
        IDLE,
        ONE_OPEN,
        COMPARE,
        SHOW_MISS,
        DONE
    } state_t;

    state_t             state_reg;
    logic [COLOR_W-1:0] color_reg [8];
    logic [1:0]         sq_reg [8];
    logic [2:0]         first_idx_reg;
    logic [2:0]         second_idx_reg;
    logic [CNT_W-1:0]   hold_cnt_reg;
    logic [2:0]         match_count_reg;
    logic [7:0]         miss_count_reg;
    logic               match_pulse_reg;
    logic               miss_pulse_reg;
    logic               game_over_reg;

    logic sel_hidden;
    logic legal_first;
    logic legal_second;

    // Only a still-hidden square can be opened; the second pick must be a different square.
    always_comb begin
        sel_hidden   = (sq_reg[sel_index] == SQ_HIDDEN);
        legal_first  = sel_valid && sel_hidden && (state_reg == IDLE);
        legal_second = sel_valid && sel_hidden && (state_reg == ONE_OPEN)
                       && (sel_index != first_idx_reg);
    end

    // Game state machine: new_game has priority over everything except reset.
    always_ff @(posedge clk25MHz or posedge rst) begin
        if (rst) begin
            state_reg       <= WAIT_NEW;
            first_idx_reg   <= '0;
            second_idx_reg  <= '0;
            hold_cnt_reg    <= '0;
            match_count_reg <= '0;
            miss_count_reg  <= '0;
            match_pulse_reg <= 1'b0;
            miss_pulse_reg  <= 1'b0;
            game_over_reg   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                color_reg[i] <= '0;
                sq_reg[i]    <= SQ_HIDDEN;
            end
        end else begin
            match_pulse_reg <= 1'b0;
            miss_pulse_reg  <= 1'b0;
            if (new_game) begin
                for (int i = 0; i < 8; i++) begin
                    color_reg[i] <= colors[i*COLOR_W +: COLOR_W];
                    sq_reg[i]    <= SQ_HIDDEN;
                end
                match_count_reg <= '0;
                miss_count_reg  <= '0;
                hold_cnt_reg    <= '0;
                game_over_reg   <= 1'b0;
                state_reg       <= IDLE;
            end else begin
                case (state_reg)
                    WAIT_NEW: ;
                    IDLE: begin
                        if (legal_first) begin
                            first_idx_reg     <= sel_index;
                            sq_reg[sel_index] <= SQ_REVEALED;
                            state_reg         <= ONE_OPEN;
                        end
                    end
                    ONE_OPEN: begin
                        if (legal_second) begin
                            second_idx_reg    <= sel_index;
                            sq_reg[sel_index] <= SQ_REVEALED;
                            state_reg         <= COMPARE;
                        end
                    end
                    COMPARE: begin
                        if (color_reg[first_idx_reg] == color_reg[second_idx_reg]) begin
                            sq_reg[first_idx_reg]  <= SQ_MATCHED;
                            sq_reg[second_idx_reg] <= SQ_MATCHED;
                            match_count_reg        <= match_count_reg + 3'd1;
                            match_pulse_reg        <= 1'b1;
                            if (match_count_reg == 3'd3) begin
                                game_over_reg <= 1'b1;
                                state_reg     <= DONE;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            miss_pulse_reg <= 1'b1;
                            if (miss_count_reg != 8'hFF) begin
                                miss_count_reg <= miss_count_reg + 8'd1;
                            end
                            hold_cnt_reg <= '0;
                            state_reg    <= SHOW_MISS;
                        end
                    end
                    SHOW_MISS: begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            sq_reg[first_idx_reg]  <= SQ_HIDDEN;
                            sq_reg[second_idx_reg] <= SQ_HIDDEN;
                            hold_cnt_reg           <= '0;
                            state_reg              <= IDLE;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
                        end
                    end
                    DONE: ;
                    default: state_reg <= WAIT_NEW;
                endcase
            end
        end
    end

    // Selects are refused whenever the machine is not waiting for a pick.
    always_comb begin
        case (state_reg)
            IDLE, ONE_OPEN: busy = 1'b0;
            default:        busy = 1'b1;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pack
            assign square_state[2*gi +: 2] = sq_reg[gi];
        end
    endgenerate

    assign match_count = match_count_reg;
    assign miss_count  = miss_count_reg;
    assign match_pulse = match_pulse_reg;
    assign miss_pulse  = miss_pulse_reg;
    assign game_over   = game_over_reg;

endmodule
